card_dealer: RTL and testbench

Parametrised multi-player turn controller and card dealer for the card-game datapath. It rotates the active turn across NUM_PLAYERS players and draws one pseudo-random card per turn from a Galois-free Fibonacci LFSR. It stores each player's latest card in a per-player hand register, counts completed rounds, and flags game over after MAX_ROUNDS. It replaces the separate two-player turn, counter, random-generator, card-value and demux logic with one sequential block.

---
 rtl/card_dealer.sv | 211 +++++++++++++++++++++
 tb/tb_card_dealer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
//
// Multi-player turn controller and card dealer. The active turn rotates over
// NUM_PLAYERS players. Each turn draws one card from a Fibonacci LFSR. The
// drawn card is kept in a per-player hand register. Completed rounds are
// counted, and the game ends after MAX_ROUNDS full rotations.
//
// State table:
//   IDLE | waiting for start after reset; no game in progress
//   DEAL | one cycle: advance LFSR, decode card, write hand of current player
//   WAIT | waiting for the current player to end the turn
//   DONE | game over; outputs and hands hold until the next start
//
// Optional build macro:
//   DEALER_SEED_EN - adds seed_load/seed ports. These let the LFSR be reseeded
//                    while the block is in IDLE or DONE.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   pulse, begins a new game (IDLE/DONE only)
//   end_turn       in   pulse, a player ends their turn
//   end_player     in   id of the player issuing end_turn
//   seed_load      in   (DEALER_SEED_EN) load seed into LFSR (IDLE/DONE only)
//   seed           in   (DEALER_SEED_EN) seed value; zero selects LFSR_SEED
//   current_player out  id of the player whose turn it is
//   card_valid     out  one-cycle pulse when a card is dealt
//   card_color     out  dealt colour 1..3
//   card_number    out  dealt number 1..NUM_MAX
//   hand_flat      out  per-player {color,number}, player p at [5p+4:5p]
//   round_count    out  completed rounds
//   illegal        out  one-cycle pulse when an end_turn is rejected
//   game_over      out  high while in DONE
// -----------------------------------------------------------------------------
module card_dealer #(
    parameter int                NUM_PLAYERS = 2,
    parameter int                MAX_ROUNDS  = 3,
    parameter int                LFSR_W      = 5,
    parameter logic [LFSR_W-1:0] LFSR_TAPS   = 5'b10100,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 5'b11100,
    parameter int                NUM_MAX     = 5,
    localparam int               PW = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int               RW = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     end_turn,
    input  logic [PW-1:0]            end_player,
`ifdef DEALER_SEED_EN
    input  logic                     seed_load,
    input  logic [LFSR_W-1:0]        seed,
`endif
    output logic [PW-1:0]            current_player,
    output logic                     card_valid,
    output logic [1:0]               card_color,
    output logic [2:0]               card_number,
    output logic [5*NUM_PLAYERS-1:0] hand_flat,
    output logic [RW-1:0]            round_count,
    output logic                     illegal,
    output logic                     game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAL = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0]    NUM_MAX_L  = 3'(NUM_MAX);
    localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
    localparam logic [RW-1:0] ROUND_LIMIT = RW'(MAX_ROUNDS);

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [PW-1:0]     cur_q, cur_d;
    logic [RW-1:0]     round_q, round_d;
    logic [1:0]        color_q, color_d;
    logic [2:0]        number_q, number_d;
    logic              card_valid_q, card_valid_d;
    logic              illegal_q, illegal_d;
    logic [4:0]        hand_q [NUM_PLAYERS];
    logic [4:0]        hand_d [NUM_PLAYERS];

    logic [LFSR_W-1:0] lfsr_next;
    logic [1:0]        color_next;
    logic [2:0]        number_next;
    logic [RW-1:0]     round_inc;
    logic              wrap;

    // Card decode works on the value the LFSR is about to take, so the card
    // registered in DEAL always matches the LFSR state left behind.
    always_comb begin
        lfsr_next = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        case (lfsr_next[LFSR_W-1 -: 2])
            2'b00:   color_next = 2'd1;
            2'b01:   color_next = 2'd2;
            2'b10:   color_next = 2'd3;
            default: color_next = 2'd1;
        endcase
        // The remainder is at most NUM_MAX-1 <= 6, so adding 1 stays in 3 bits.
        number_next = (lfsr_next[2:0] % NUM_MAX_L) + 3'd1;
        wrap        = (cur_q == LAST_PLAYER);
        round_inc   = round_q + RW'(1);
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cur_d        = cur_q;
        round_d      = round_q;
        color_d      = color_q;
        number_d     = number_q;
        hand_d       = hand_q;
        card_valid_d = 1'b0;
        illegal_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
`ifdef DEALER_SEED_EN
                // A seed load in the same cycle as start drops the start.
                if (seed_load) begin
                    lfsr_d = (seed == '0) ? LFSR_SEED : seed;
                end else
`endif
                if (start) begin
                    cur_d   = '0;
                    round_d = '0;
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        hand_d[p] = '0;
                    end
                    state_d = DEAL;
                end
            end

            DEAL: begin
                lfsr_d       = lfsr_next;
                color_d      = color_next;
                number_d     = number_next;
                card_valid_d = 1'b1;
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (PW'(p) == cur_q) begin
                        hand_d[p] = {color_next, number_next};
                    end
                end
                state_d = WAIT;
            end

            WAIT: begin
                if (end_turn) begin
                    if (end_player == cur_q) begin
                        if (wrap) begin
                            cur_d   = '0;
                            round_d = round_inc;
                            state_d = (round_inc == ROUND_LIMIT) ? DONE : DEAL;
                        end else begin
                            cur_d   = cur_q + PW'(1);
                            state_d = DEAL;
                        end
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            cur_q        <= '0;
            round_q      <= '0;
            color_q      <= '0;
            number_q     <= '0;
            card_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            hand_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cur_q        <= cur_d;
            round_q      <= round_d;
            color_q      <= color_d;
            number_q     <= number_d;
            card_valid_q <= card_valid_d;
            illegal_q    <= illegal_d;
            hand_q       <= hand_d;
        end
    end

    always_comb begin
        hand_flat = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            hand_flat[5*p +: 5] = hand_q[p];
        end
    end

    assign current_player = cur_q;
    assign card_valid     = card_valid_q;
    assign card_color     = color_q;
    assign card_number    = number_q;
    assign round_count    = round_q;
    assign illegal        = illegal_q;
    assign game_over      = (state_q == DONE);

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       end_turn;
    logic [0:0] end_player;
    logic [0:0] current_player;
    logic       card_valid;
    logic [1:0] card_color;
    logic [2:0] card_number;
    logic [9:0] hand_flat;
    logic [1:0] round_count;
    logic       illegal;
    logic       game_over;
`ifdef DEALER_SEED_EN
    logic       seed_load = 1'b0;
    logic [4:0] seed = '0;
`endif

    card_dealer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .end_turn       (end_turn),
        .end_player     (end_player),
`ifdef DEALER_SEED_EN
        .seed_load      (seed_load),
        .seed           (seed),
`endif
        .current_player (current_player),
        .card_valid     (card_valid),
        .card_color     (card_color),
        .card_number    (card_number),
        .hand_flat      (hand_flat),
        .round_count    (round_count),
        .illegal        (illegal),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_card;
        int player;
        int color;
        int number;
        int rounds;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_card(input int p, input int c, input int n, input int r);
        exp_t e;
        e.is_card = 1'b1; e.player = p; e.color = c; e.number = n; e.rounds = r;
        sb.push_back(e);
    endtask

    task automatic push_illegal(input int p);
        exp_t e;
        e.is_card = 1'b0; e.player = p; e.color = 0; e.number = 0; e.rounds = 0;
        sb.push_back(e);
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (card_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_card_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("event_is_card", 1, int'(e.is_card));
                    chk("card_player", int'(current_player), e.player);
                    chk("card_color", int'(card_color), e.color);
                    chk("card_number", int'(card_number), e.number);
                    chk("hand_slot", int'(hand_flat[5*e.player +: 5]), e.color * 8 + e.number);
                    chk("card_rounds", int'(round_count), e.rounds);
                end
            end
            if (illegal) begin
                if (sb.size() == 0) begin
                    chk("unexpected_illegal", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("event_is_illegal", 0, int'(e.is_card));
                    chk("illegal_player", int'(current_player), e.player);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_end(input int p);
        end_turn   = 1'b1;
        end_player = 1'(p);
        tick();
        end_turn   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        // Let the monitor see the last event's negedge before moving on.
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            chk({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_player"}, int'(current_player), 0);
        chk({name, "_card_valid"}, int'(card_valid), 0);
        chk({name, "_color"}, int'(card_color), 0);
        chk({name, "_number"}, int'(card_number), 0);
        chk({name, "_hand"}, int'(hand_flat), 0);
        chk({name, "_rounds"}, int'(round_count), 0);
        chk({name, "_illegal"}, int'(illegal), 0);
        chk({name, "_game_over"}, int'(game_over), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; end_turn = 1'b0; end_player = '0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // First deal after start: lfsr 11000 -> color 1, number 1.
        push_card(0, 1, 1, 0);
        pulse_start();
        chk("start_lat_deal_cycle", int'(card_valid), 0);
        tick();
        chk("start_lat_valid", int'(card_valid), 1);
        chk("hand0_first", int'(hand_flat[4:0]), 5'b01001);
        drain("first_card");

        // Player 0 ends; lfsr 10001 -> color 3, number 2 for player 1.
        push_card(1, 3, 2, 0);
        pulse_end(0);
        chk("accept_player_update", int'(current_player), 1);
        drain("card_p1");

        // Wrong player ends the turn.
        push_illegal(1);
        pulse_end(0);
        drain("illegal");
        chk("illegal_player_hold", int'(current_player), 1);
        chk("illegal_no_card", int'(card_valid), 0);

        // Player 1 ends; round 1 done; lfsr 00011 -> color 1, number 4.
        push_card(0, 1, 4, 1);
        pulse_end(1);
        drain("card_r1");
        chk("round_after_wrap", int'(round_count), 1);

        // lfsr 00110 -> color 1, number 2.
        push_card(1, 1, 2, 1);
        pulse_end(0);
        drain("card_4");
        // lfsr 01101 -> color 2, number 1.
        push_card(0, 2, 1, 2);
        pulse_end(1);
        drain("card_5");
        // lfsr 11011 -> color 1, number 4.
        push_card(1, 1, 4, 2);
        pulse_end(0);
        drain("card_6");

        // Sixth accepted end_turn ends the game, no card.
        pulse_end(1);
        chk("game_over_rise", int'(game_over), 1);
        chk("final_rounds", int'(round_count), 3);
        chk("final_player", int'(current_player), 0);
        chk("final_hands", int'(hand_flat), 10'b01100_10001);

        // end_turn in DONE is ignored by both flags.
        pulse_end(0);
        pulse_end(1);
        repeat (3) tick();
        chk("done_hold", int'(game_over), 1);
        chk("done_hands_hold", int'(hand_flat), 10'b01100_10001);

        // Restart without reseed: lfsr 10111 -> color 3, number 3.
        push_card(0, 3, 3, 0);
        pulse_start();
        chk("restart_hands_clear", int'(hand_flat), 0);
        chk("restart_rounds_clear", int'(round_count), 0);
        chk("restart_game_over_low", int'(game_over), 0);
        drain("restart");

        // lfsr 01110 -> color 2, number 2; lfsr 11101 -> color 1, number 1.
        push_card(1, 2, 2, 0);
        pulse_end(0);
        drain("g2_card2");
        push_card(0, 1, 1, 1);
        pulse_end(1);
        drain("g2_card3");

        // Asynchronous reset mid-cycle in WAIT of round 2.
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();

        // LFSR back to 11100, so the first card is 11000 again.
        push_card(0, 1, 1, 0);
        pulse_start();
        drain("after_rst");

        repeat (2) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
